// File: rtl/spi_slave_core.sv
// spi_slave_core
//   SPI slave that runs entirely on the system clock. sclk, ss and mosi are
//   oversampled through synchronisers, and edges are found by comparing the
//   last two synchronised sclk samples. All four CPOL/CPHA modes are
//   supported, along with any word width of 2 or more and either bit order.
//   Several words can run back to back inside one ss frame.
//
//   State | meaning
//   IDLE  | no frame; miso_oe low; waits for an armed ss falling edge
//   LOAD  | one cycle; takes tx_data (or DEFAULT_TX) and starts the word
//   SHIFT | samples mosi and shifts miso on sclk edges until ss rises
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   sclk, ss, mosi      asynchronous SPI pins from the master
//   miso, miso_oe       serial output and its enable
//   tx_data/tx_valid    next word to send; tx_ready pulses when it is taken
//   rx_data/rx_valid    last received word; rx_valid pulses when it updates
//   busy                synchronised ss asserted
//   underrun            pulses when DEFAULT_TX is loaded instead of tx_data
//   frame_err           pulses when ss rises with a partial word in flight
module spi_slave_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = '1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  underrun,
    output logic                  frame_err
);

    localparam logic SCLK_IDLE = (CPOL != 0);
    localparam int   CNT_W     = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] settle;
    logic                   sclk_d;
    logic                   ss_d;
    logic                   armed;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  shift_tx;
    logic [DATA_WIDTH-1:0]  shift_rx;

    logic                   sclk_s, ss_s, mosi_s;
    logic                   lead_e, trail_e, sample_e, shift_e;
    logic                   ss_fall, ss_rise;
    logic                   word_done, load_now;
    logic [DATA_WIDTH-1:0]  load_word, load_adv, tx_adv, rx_next;
    logic                   tx_first, tx_bit;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign ss_s    = ss_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];

    assign lead_e   = (sclk_d == SCLK_IDLE) && (sclk_s != SCLK_IDLE);
    assign trail_e  = (sclk_d != SCLK_IDLE) && (sclk_s == SCLK_IDLE);
    assign sample_e = (CPHA == 0) ? lead_e : trail_e;
    assign shift_e  = (CPHA == 0) ? trail_e : lead_e;

    // The chains are flushed to ss=1 on reset. armed is set only once a
    // genuine high level from the pin has propagated through, so an ss held
    // low across reset cannot start a frame.
    assign ss_fall = armed && ss_d && !ss_s;
    assign ss_rise = !ss_d && ss_s;

    assign word_done = (state == S_SHIFT) && !ss_rise && sample_e &&
                       (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign load_now  = !reset && (((state == S_LOAD) && !ss_rise) || word_done);

    // Decoded rather than registered so that the handshake pulse lands in the
    // same cycle tx_data is captured.
    assign tx_ready  = load_now && tx_valid;
    assign underrun  = load_now && !tx_valid;

    assign load_word = tx_valid ? tx_data : DEFAULT_TX;

    always_comb begin
        if (MSB_FIRST != 0) begin
            tx_first = load_word[DATA_WIDTH-1];
            tx_bit   = shift_tx[DATA_WIDTH-1];
            load_adv = {load_word[DATA_WIDTH-2:0], 1'b0};
            tx_adv   = {shift_tx[DATA_WIDTH-2:0], 1'b0};
            rx_next  = {shift_rx[DATA_WIDTH-2:0], mosi_s};
        end else begin
            tx_first = load_word[0];
            tx_bit   = shift_tx[0];
            load_adv = {1'b0, load_word[DATA_WIDTH-1:1]};
            tx_adv   = {1'b0, shift_tx[DATA_WIDTH-1:1]};
            rx_next  = {mosi_s, shift_rx[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            settle    <= '0;
            sclk_d    <= SCLK_IDLE;
            ss_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            if (settle[SYNC_STAGES-1] && ss_s) begin
                armed <= 1'b1;
            end
        end
    end

    // shift_tx always holds the bits still to be driven. With CPHA=0 the
    // first bit leaves at LOAD, so the word is stored pre-advanced; a word
    // reloaded mid-frame is stored whole and its first bit goes out on the
    // next shift edge, which makes both phases share one shift rule.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            shift_tx  <= '0;
            shift_rx  <= '0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= armed && !ss_s;
            case (state)
                S_IDLE: begin
                    miso_oe <= 1'b0;
                    bit_cnt <= '0;
                    if (ss_fall) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ss_rise) begin
                        miso_oe <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        miso_oe <= 1'b1;
                        bit_cnt <= '0;
                        if (CPHA == 0) begin
                            miso     <= tx_first;
                            shift_tx <= load_adv;
                        end else begin
                            shift_tx <= load_word;
                        end
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ss_rise) begin
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                        bit_cnt <= '0;
                        miso_oe <= 1'b0;
                        state   <= S_IDLE;
                    end else if (sample_e) begin
                        shift_rx <= rx_next;
                        if (word_done) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            shift_tx <= load_word;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (shift_e) begin
                        miso     <= tx_bit;
                        shift_tx <= tx_adv;
                    end
                end
                default: begin
                    miso_oe <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// Two instances: index 0 is mode 0 MSB-first, index 1 is mode 3 LSB-first.
module tb_spi_slave_core;

    localparam int H = 6;

    typedef struct {
        int          idx;
        int          nbits;
        logic [31:0] mw;
        int          ntx;
        logic [31:0] tw;
        int          exp_nrx;
        logic [31:0] exp_rx;
        logic [31:0] exp_rd;
        int          exp_rdy;
        int          exp_unr;
        int          exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sclk_p = 2'b10;
    logic [1:0] ss_p = 2'b11;
    logic [1:0] mosi_p = 2'b00;
    logic [1:0] tx_valid_p;
    logic [7:0] tx_data_p [2];
    logic [1:0] miso_w, oe_w, txr_w, rxv_w, busy_w, unr_w, ferr_w;
    logic [7:0] rx_data_w [2];

    logic [7:0] txbuf [2][16];
    int         txhead [2] = '{0, 0};
    int         txlen [2] = '{0, 0};
    logic [1:0] adv = 2'b00;
    int         n_rdy [2] = '{0, 0};
    int         n_unr [2] = '{0, 0};
    int         n_ferr [2] = '{0, 0};
    int         n_rx [2] = '{0, 0};
    logic [7:0] rxbuf [2][16];
    logic [7:0] last_rx [2] = '{8'h00, 8'h00};

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign tx_valid_p[0] = (txhead[0] < txlen[0]);
    assign tx_valid_p[1] = (txhead[1] < txlen[1]);
    assign tx_data_p[0]  = txbuf[0][txhead[0] % 16];
    assign tx_data_p[1]  = txbuf[1][txhead[1] % 16];

    spi_slave_core #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut0 (
        .clk(clk), .reset(reset), .sclk(sclk_p[0]), .ss(ss_p[0]), .mosi(mosi_p[0]),
        .miso(miso_w[0]), .miso_oe(oe_w[0]), .tx_data(tx_data_p[0]),
        .tx_valid(tx_valid_p[0]), .tx_ready(txr_w[0]), .rx_data(rx_data_w[0]),
        .rx_valid(rxv_w[0]), .busy(busy_w[0]), .underrun(unr_w[0]), .frame_err(ferr_w[0])
    );

    spi_slave_core #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) dut1 (
        .clk(clk), .reset(reset), .sclk(sclk_p[1]), .ss(ss_p[1]), .mosi(mosi_p[1]),
        .miso(miso_w[1]), .miso_oe(oe_w[1]), .tx_data(tx_data_p[1]),
        .tx_valid(tx_valid_p[1]), .tx_ready(txr_w[1]), .rx_data(rx_data_w[1]),
        .rx_valid(rxv_w[1]), .busy(busy_w[1]), .underrun(unr_w[1]), .frame_err(ferr_w[1])
    );

    // Pulse counters and TX source. A consumed word is retired one negedge
    // after tx_ready is seen, i.e. after the posedge that captured it.
    always @(negedge clk) begin
        logic r;
        for (int i = 0; i < 2; i++) begin
            r = txr_w[i];
            if (adv[i]) txhead[i] = txhead[i] + 1;
            adv[i] = r;
            if (r) n_rdy[i] = n_rdy[i] + 1;
            if (unr_w[i]) n_unr[i] = n_unr[i] + 1;
            if (ferr_w[i]) n_ferr[i] = n_ferr[i] + 1;
            if (rxv_w[i]) begin
                rxbuf[i][n_rx[i] % 16] = rx_data_w[i];
                n_rx[i] = n_rx[i] + 1;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_tx(input int idx, input int ntx, input logic [31:0] tw);
        for (int k = 0; k < ntx; k++) txbuf[idx][(txhead[idx] + k) % 16] = tw[8*k +: 8];
        txlen[idx] = txhead[idx] + ntx;
    endtask

    // One bit as the master sees it: drive mosi, capture miso at the
    // master's sample edge.
    task automatic spi_bit(input int idx, input logic b, output logic r);
        logic cpol;
        cpol = (idx == 1);
        if (idx == 0) begin
            mosi_p[idx] = b;
            wait_clk(H);
            r = miso_w[idx];
            sclk_p[idx] = ~cpol;
            wait_clk(H);
            sclk_p[idx] = cpol;
        end else begin
            sclk_p[idx] = ~cpol;
            mosi_p[idx] = b;
            wait_clk(H);
            r = miso_w[idx];
            sclk_p[idx] = cpol;
            wait_clk(H);
        end
    endtask

    function automatic int bitpos(input int idx, input int b);
        return (idx == 0) ? (7 - b) : b;
    endfunction

    task automatic spi_frame(input int idx, input int nbits, input logic [31:0] mw,
                             output logic [31:0] rd);
        logic r;
        int   p;
        rd = '0;
        ss_p[idx] = 1'b0;
        wait_clk(2 * H);
        for (int b = 0; b < nbits; b++) begin
            p = (b / 8) * 8 + bitpos(idx, b % 8);
            spi_bit(idx, mw[p], r);
            rd[p] = r;
        end
        wait_clk(H);
        ss_p[idx] = 1'b1;
        wait_clk(2 * H);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int          i, r0, rdy0, unr0, ferr0, full;
        logic [31:0] rd;
        i = v.idx;
        r0 = n_rx[i]; rdy0 = n_rdy[i]; unr0 = n_unr[i]; ferr0 = n_ferr[i];
        load_tx(i, v.ntx, v.tw);
        spi_frame(i, v.nbits, v.mw, rd);
        full = v.exp_nrx;
        chk({tag, " rx_count"}, n_rx[i] - r0, v.exp_nrx);
        for (int k = 0; k < full && k < 4; k++) begin
            chk({tag, " rx_word"}, rxbuf[i][(r0 + k) % 16], v.exp_rx[8*k +: 8]);
            chk({tag, " miso_word"}, rd[8*k +: 8], v.exp_rd[8*k +: 8]);
        end
        chk({tag, " tx_ready_count"}, n_rdy[i] - rdy0, v.exp_rdy);
        chk({tag, " underrun_count"}, n_unr[i] - unr0, v.exp_unr);
        chk({tag, " frame_err_count"}, n_ferr[i] - ferr0, v.exp_ferr);
        if (full > 0) last_rx[i] = v.exp_rx[8*(full-1) +: 8];
        chk({tag, " rx_data_hold"}, rx_data_w[i], last_rx[i]);
        chk({tag, " idle_oe_busy"}, {oe_w[i], busy_w[i]}, 2'b00);
    endtask

    function automatic logic [31:0] out_vec(input int i);
        return {17'd0, miso_w[i], oe_w[i], txr_w[i], rxv_w[i], busy_w[i], unr_w[i],
                ferr_w[i], rx_data_w[i]};
    endfunction

    vec_t vecs [7];

    initial begin
        vec_t        v;
        logic        r;
        logic [7:0]  pre;
        int          rdy0, unr0, ferr0, r0, loads;

        vecs[0] = '{0,  8, 32'hA5,   1, 32'h3C,     1, 32'hA5,   32'h3C,   1, 1, 0};
        vecs[1] = '{1,  8, 32'hA5,   1, 32'h3C,     1, 32'hA5,   32'h3C,   1, 1, 0};
        vecs[2] = '{0, 16, 32'h2211, 2, 32'h5AC3,   2, 32'h2211, 32'h5AC3, 2, 1, 0};
        vecs[3] = '{0,  8, 32'h96,   0, 32'h0,      1, 32'h96,   32'hFF,   0, 2, 0};
        vecs[4] = '{0,  3, 32'h07,   1, 32'h77,     0, 32'h0,    32'h0,    1, 0, 1};
        vecs[5] = '{1, 16, 32'h3CF0, 3, 32'h030201, 2, 32'h3CF0, 32'h0201, 3, 0, 0};
        vecs[6] = '{1,  5, 32'h1B,   0, 32'h0,      0, 32'h0,    32'h0,    0, 1, 1};

        wait_clk(5);
        chk("reset_outputs_0", out_vec(0), 32'h0);
        chk("reset_outputs_1", out_vec(1), 32'h0);
        reset = 1'b0;
        wait_clk(10);

        for (int n = 0; n < 7; n++) run_vec($sformatf("vec%0d", n), vecs[n]);

        // ss low with no TX data and no sclk: one underrun at LOAD, first
        // default bit on miso, clean close.
        load_tx(0, 0, 32'h0);
        rdy0 = n_rdy[0]; unr0 = n_unr[0]; ferr0 = n_ferr[0];
        ss_p[0] = 1'b0;
        wait_clk(2 * H);
        chk("empty_underrun_once", n_unr[0] - unr0, 1);
        chk("empty_no_tx_ready", n_rdy[0] - rdy0, 0);
        chk("empty_oe_miso", {oe_w[0], miso_w[0], busy_w[0]}, 3'b111);
        ss_p[0] = 1'b1;
        wait_clk(2 * H);
        chk("empty_no_frame_err", n_ferr[0] - ferr0, 0);
        chk("empty_oe_off", oe_w[0], 1'b0);

        // Reset in the middle of a word, with ss held low through it.
        load_tx(0, 1, 32'h44);
        r0 = n_rx[0]; ferr0 = n_ferr[0];
        pre = 8'hC3;
        ss_p[0] = 1'b0;
        wait_clk(2 * H);
        for (int b = 0; b < 4; b++) spi_bit(0, pre[7 - b], r);
        reset = 1'b1;
        wait_clk(2);
        chk("midreset_outputs_0", out_vec(0), 32'h0);
        chk("midreset_outputs_1", out_vec(1), 32'h0);
        reset = 1'b0;
        wait_clk(1);
        chk("postreset_outputs_0", out_vec(0), 32'h0);
        last_rx[0] = 8'h00;
        last_rx[1] = 8'h00;
        for (int b = 4; b < 8; b++) spi_bit(0, pre[7 - b], r);
        wait_clk(H);
        chk("held_ss_ignored_busy", {busy_w[0], oe_w[0]}, 2'b00);
        ss_p[0] = 1'b1;
        wait_clk(2 * H);
        chk("midreset_no_rx", n_rx[0] - r0, 0);
        chk("midreset_no_frame_err", n_ferr[0] - ferr0, 0);
        v = '{0, 8, 32'h5A, 1, 32'h81, 1, 32'h5A, 32'h81, 1, 1, 0};
        run_vec("after_reset", v);

        // Random frames checked against the word-level model: each frame
        // loads one word at ss fall plus one per completed word, taking
        // queued TX words in order and DEFAULT_TX (0xFF) once they run out.
        for (int n = 0; n < 24; n++) begin
            int nw, part;
            v.idx   = $urandom_range(0, 1);
            nw      = $urandom_range(1, 3);
            part    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            v.nbits = (part != 0) ? (nw - 1) * 8 + part : nw * 8;
            v.ntx   = $urandom_range(0, 4);
            v.mw    = $urandom;
            v.tw    = $urandom;
            v.exp_nrx  = v.nbits / 8;
            v.exp_rx   = v.mw;
            v.exp_ferr = (v.nbits % 8 != 0) ? 1 : 0;
            loads      = v.exp_nrx + 1;
            v.exp_rdy  = (v.ntx < loads) ? v.ntx : loads;
            v.exp_unr  = loads - v.exp_rdy;
            v.exp_rd   = '0;
            for (int k = 0; k < 4; k++)
                v.exp_rd[8*k +: 8] = (k < v.ntx) ? v.tw[8*k +: 8] : 8'hFF;
            run_vec($sformatf("rand%0d", n), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
